// File: rtl/bus_pkg.sv
// Shared CPU bus types: memory speed classes, MEMSEL address,
// refresh FSM states.
package bus_pkg;

   typedef enum logic [1:0] {
      MEM_FAST,
      MEM_SLOW,
      MEM_XSLOW,
      MEM_VAR
   } mem_speed_type;

   localparam logic [15:0] MEMSEL_ADDR = 16'h420D;

   typedef enum logic [1:0] {
      REF_IDLE,
      REF_PENDING,
      REF_ACTIVE
   } refresh_state_type;

endpackage

// File: rtl/mem_speed_decode.sv
// Combinational address to memory-speed class decode.
// Also used by the DMA controller.
module mem_speed_decode
   import bus_pkg::*;
(
   input  logic [23:0]   addr,
   output mem_speed_type mem_speed
);

   always_comb begin
      mem_speed = MEM_SLOW;
      unique casez ({addr[22], addr[15], addr[14:13]})
         4'b1???,
         4'b01??: mem_speed = addr[23] ? MEM_VAR : MEM_SLOW;
         4'b0001: mem_speed = MEM_FAST;
         // $4000-$41FF is the joypad/old-IO window
         4'b0010: mem_speed = (addr[12:9] == 4'd0) ? MEM_XSLOW : MEM_FAST;
         4'b0000,
         4'b0011: mem_speed = MEM_SLOW;
      endcase
   end

endmodule

// File: rtl/mem_speed_ctrl.sv
// Bus-side speed request generator, MEMSEL bit and DRAM refresh stall.
// Refresh FSM present only when MEM_SPEED_REFRESH_EN is defined.
module mem_speed_ctrl
   import bus_pkg::*;
#(
   parameter int unsigned REFRESH_CYCLES = 40
) (
   input  logic          clk,
   input  logic          n_reset,
   input  logic          cpu_en,
   input  logic [23:0]   addr,
   input  logic          rd,
   input  logic          wr,
   input  logic [7:0]    wdata,
   input  logic          refresh_req,
   output logic          mem_access,
   output mem_speed_type mem_speed,
   output logic          speed_change,
   output logic          new_speed,
   output logic          stop,
   output logic          memsel,
   output logic          refresh_busy
);

   if (REFRESH_CYCLES < 1 || REFRESH_CYCLES > 255) begin : g_bad_cfg
      $error("REFRESH_CYCLES must be 1..255");
   end

   logic hit;
   logic memsel_q, memsel_d;

   mem_speed_decode u_decode (
      .addr      (addr),
      .mem_speed (mem_speed)
   );

   assign mem_access   = rd | wr;
   assign hit          = wr & ~addr[22] & (addr[15:0] == MEMSEL_ADDR);
   assign speed_change = hit;
   assign new_speed    = wdata[0];

   assign memsel_d = (cpu_en & hit) ? wdata[0] : memsel_q;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) memsel_q <= 1'b0;
      else          memsel_q <= memsel_d;
   end

   assign memsel = memsel_q;

`ifdef MEM_SPEED_REFRESH_EN

   localparam logic [7:0] RC_LAST = 8'(REFRESH_CYCLES - 1);

   refresh_state_type state_q, state_d;
   logic [7:0]        rcnt_q, rcnt_d;
   logic              req_q, req_d;
   logic              stop_q, stop_d;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= REF_IDLE;
         rcnt_q  <= 8'd0;
         req_q   <= 1'b0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
         req_q   <= req_d;
         stop_q  <= stop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      req_d   = req_q;
      unique case (state_q)
         REF_IDLE: begin
            if (refresh_req) state_d = REF_PENDING;
         end
         REF_PENDING: begin
            if (refresh_req) req_d = 1'b1;
            if (cpu_en) begin
               state_d = REF_ACTIVE;
               rcnt_d  = RC_LAST;
            end
         end
         REF_ACTIVE: begin
            if (rcnt_q == 8'd0) begin
               // a request landing on the exit clock becomes the pending one
               state_d = (req_q | refresh_req) ? REF_PENDING : REF_IDLE;
               req_d   = req_q & refresh_req;
            end else begin
               rcnt_d = rcnt_q - 8'd1;
               if (refresh_req) req_d = 1'b1;
            end
         end
         default: state_d = REF_IDLE;
      endcase
   end

   always_comb begin
      stop_d = (state_d == REF_ACTIVE);
   end

   assign stop         = stop_q;
   assign refresh_busy = (state_q != REF_IDLE);

`else

   logic unused_refresh_req;

   assign unused_refresh_req = refresh_req;
   assign stop               = 1'b0;
   assign refresh_busy       = 1'b0;

`endif

endmodule

// File: tb/tb_mem_speed_ctrl.sv
// Scoreboard bench for mem_speed_ctrl: speed map, MEMSEL, refresh stalls.
// Refresh expectations follow MEM_SPEED_REFRESH_EN.
module tb_mem_speed_ctrl;
   import bus_pkg::*;

   localparam int RC = 40;

   logic          clk = 1'b0;
   logic          n_reset;
   logic          cpu_en;
   logic [23:0]   addr;
   logic          rd;
   logic          wr;
   logic [7:0]    wdata;
   logic          refresh_req;
   logic          mem_access;
   mem_speed_type mem_speed;
   logic          speed_change;
   logic          new_speed;
   logic          stop;
   logic          memsel;
   logic          refresh_busy;

   mem_speed_ctrl #(.REFRESH_CYCLES(RC)) dut (
      .clk          (clk),
      .n_reset      (n_reset),
      .cpu_en       (cpu_en),
      .addr         (addr),
      .rd           (rd),
      .wr           (wr),
      .wdata        (wdata),
      .refresh_req  (refresh_req),
      .mem_access   (mem_access),
      .mem_speed    (mem_speed),
      .speed_change (speed_change),
      .new_speed    (new_speed),
      .stop         (stop),
      .memsel       (memsel),
      .refresh_busy (refresh_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      mem_speed_type sp;
      logic          sc;
      logic          ns;
   } bexp_t;

   typedef struct {
      int start;
      int len;
   } wexp_t;

   bexp_t bq[$];
   wexp_t wq[$];

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic model_memsel = 1'b0;
   logic prev_stop = 1'b0;
   int   win_start = 0;
   logic win_open = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic mem_speed_type ref_speed(input logic [23:0] a);
      int b;
      int o;
      b = int'(a[23:16]);
      o = int'(a[15:0]);
      if (b >= 'h40 && b < 'h80) return MEM_SLOW;
      if (b >= 'hC0) return MEM_VAR;
      if (o < 'h2000) return MEM_SLOW;
      if (o < 'h4000) return MEM_FAST;
      if (o < 'h4200) return MEM_XSLOW;
      if (o < 'h6000) return MEM_FAST;
      if (o < 'h8000) return MEM_SLOW;
      return (b >= 'h80) ? MEM_VAR : MEM_SLOW;
   endfunction

   function automatic logic ref_hit(input logic [23:0] a, input logic w);
      int b;
      b = int'(a[23:16]);
      return w && (b < 'h40 || (b >= 'h80 && b < 'hC0))
             && a[15:0] == 16'h420D;
   endfunction

   // monitor: pops bus expectations, measures stall windows
   always @(negedge clk) begin
      bexp_t e;
      wexp_t w;
      if (mem_access) begin
         if (bq.size() == 0) begin
            chk("bus_unexpected", 1, 0);
         end else begin
            e = bq.pop_front();
            chk("mem_speed", int'(mem_speed), int'(e.sp));
            chk("speed_change", speed_change, e.sc);
            chk("new_speed", new_speed, e.ns);
         end
      end
      chk("memsel", memsel, model_memsel);
      if (stop && !prev_stop) begin
         win_start = cyc;
         win_open = 1'b1;
      end
      if (!stop && prev_stop) begin
         win_open = 1'b0;
         if (wq.size() == 0) begin
            chk("stall_unexpected", win_start, 0);
         end else begin
            w = wq.pop_front();
            chk("stall_start", win_start, w.start);
            chk("stall_len", cyc - win_start, w.len);
         end
      end
      prev_stop = stop;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic [23:0] a, input logic r, input logic w,
                      input logic [7:0] d, input logic ce,
                      input mem_speed_type es);
      bexp_t e;
      addr = a;
      rd = r;
      wr = w;
      wdata = d;
      cpu_en = ce;
      e.sp = es;
      e.sc = ref_hit(a, w);
      e.ns = d[0];
      if (r || w) bq.push_back(e);
      tick();
      if (ce && ref_hit(a, w)) model_memsel = d[0];
      rd = 1'b0;
      wr = 1'b0;
      cpu_en = 1'b0;
   endtask

   task automatic pulse_req();
      refresh_req = 1'b1;
      tick();
      refresh_req = 1'b0;
   endtask

   // cycle-boundary pulse; exp_len > 0 means a stall is expected to start
   task automatic ce(input int exp_len, output int start);
      wexp_t w;
      start = cyc + 1;
`ifdef MEM_SPEED_REFRESH_EN
      if (exp_len > 0) begin
         w.start = start;
         w.len = exp_len;
         wq.push_back(w);
      end
`endif
      cpu_en = 1'b1;
      tick();
      cpu_en = 1'b0;
   endtask

   logic [23:0]   map_a [9] = '{24'h000000, 24'h002100, 24'h004016,
                                24'h004200, 24'h006000, 24'h008000,
                                24'h7E0000, 24'h808000, 24'hC00000};
   mem_speed_type map_e [9] = '{MEM_SLOW, MEM_FAST, MEM_XSLOW,
                                MEM_FAST, MEM_SLOW, MEM_SLOW,
                                MEM_SLOW, MEM_VAR, MEM_VAR};
   logic [15:0]   offs [12] = '{16'h0000, 16'h1FFF, 16'h2000, 16'h3FFF,
                                16'h4000, 16'h41FF, 16'h4200, 16'h420D,
                                16'h5FFF, 16'h6000, 16'h7FFF, 16'h8000};

   initial begin
      int s;
      int s2;
      logic [23:0] a;
      logic r;
      n_reset = 1'b0;
      cpu_en = 1'b0;
      addr = 24'h0;
      rd = 1'b0;
      wr = 1'b0;
      wdata = 8'h0;
      refresh_req = 1'b0;
      #2;
      chk("rst_stop", stop, 0);
      chk("rst_memsel", memsel, 0);
      chk("rst_busy", refresh_busy, 0);
      chk("rst_access", mem_access, 0);
      @(posedge clk);
      #1;
      n_reset = 1'b1;
      tick();

      for (int i = 0; i < 9; i++) bus(map_a[i], 1'b1, 1'b0, 8'h00, 1'b1, map_e[i]);

      bus(24'h80420D, 1'b0, 1'b1, 8'h01, 1'b1, MEM_FAST);
      chk("memsel_set", memsel, 1);
      bus(24'h00420D, 1'b0, 1'b1, 8'h00, 1'b1, MEM_FAST);
      chk("memsel_clr", memsel, 0);
      bus(24'h40420D, 1'b0, 1'b1, 8'h01, 1'b1, MEM_SLOW);
      chk("memsel_bank40", memsel, 0);
      bus(24'h00420D, 1'b0, 1'b1, 8'h01, 1'b0, MEM_FAST);
      chk("memsel_no_ce", memsel, 0);

      for (int i = 0; i < 60; i++) begin
         a = {8'($urandom), offs[$urandom_range(11)]};
         if ($urandom_range(3) == 0) a[15:0] = 16'($urandom);
         r = 1'($urandom);
         bus(a, r, !r, 8'($urandom), 1'($urandom), ref_speed(a));
      end

      // single refresh, boundary 3 clocks after the request
      pulse_req();
      tick();
      tick();
      ce(RC, s);
      repeat (RC + 2) tick();
      chk("busy_after_1", refresh_busy, 0);

      // request and boundary in the same clock: boundary missed
      refresh_req = 1'b1;
      cpu_en = 1'b1;
      tick();
      refresh_req = 1'b0;
      cpu_en = 1'b0;
      repeat ($urandom_range(1, 4)) tick();
      chk("same_clk_no_stall", stop, 0);
      ce(RC, s);
      repeat (RC + 2) tick();
      chk("busy_after_2", refresh_busy, 0);

      // two requests during a stall: exactly one more stall
      pulse_req();
      ce(RC, s);
      repeat (4) tick();
      pulse_req();
      repeat (4) tick();
      pulse_req();
      while (cyc < s + RC) tick();
      repeat ($urandom_range(0, 5)) tick();
      ce(RC, s2);
      repeat (RC + 3) tick();
      chk("busy_after_q", refresh_busy, 0);
      ce(0, s2);
      repeat (RC + 2) tick();

      // reset at stall clock 10
      bus(24'h80420D, 1'b0, 1'b1, 8'h01, 1'b1, MEM_FAST);
      pulse_req();
      ce(10, s);
      while (cyc < s + 10) tick();
      n_reset = 1'b0;
      model_memsel = 1'b0;
      #1;
      chk("arst_stop", stop, 0);
      chk("arst_memsel", memsel, 0);
      chk("arst_busy", refresh_busy, 0);
      tick();
      n_reset = 1'b1;
      tick();
      ce(0, s);
      repeat (RC + 2) tick();

`ifndef MEM_SPEED_REFRESH_EN
      repeat (5) begin
         pulse_req();
         ce(0, s);
      end
      repeat (RC) tick();
      chk("off_stop", stop, 0);
`endif

      chk("bus_q_left", bq.size(), 0);
      chk("win_q_left", wq.size(), 0);
      chk("win_open", win_open, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
